conv_window_addr_gen: RTL

- Sits directly downstream of the array controller's config registers and upstream of the input memory read port and the PE row feeders.
- On a start pulse, walks every 3x3 convolution window of a C-channel W x H input map stored plane-major in input memory. One read address is emitted per cycle under a valid/ready handshake, tagged with kernel index, channel and window/frame boundary flags.
- The controller's compute mode drives start and consumes done.

---
 rtl/conv_window_addr_gen_if.sv | 24 ++
 rtl/conv_window_addr_gen.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/conv_window_addr_gen_if.sv
// Read-address stream from the convolution window walker to the input memory
// read port and PE row feeders: one address plus its tags per handshake.
interface conv_window_addr_gen_if #(
   parameter int ADDR_W = 16,
   parameter int DIM_W  = 8
);
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_addr;
   logic [3:0]        out_kidx;
   logic [DIM_W-1:0]  out_chan;
   logic              out_win_last;
   logic              out_frame_last;

   modport master (
      output out_valid, out_addr, out_kidx, out_chan, out_win_last, out_frame_last,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_addr, out_kidx, out_chan, out_win_last, out_frame_last,
      output out_ready
   );
endinterface

// File: rtl/conv_window_addr_gen.sv
// Walks every 3x3 window of a C x H x W plane-major input map and streams one
// read address per accepted handshake, tagged with kernel index, channel and flags.
module conv_window_addr_gen #(
   parameter int ADDR_W = 16,
   parameter int DIM_W  = 8
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   start,
   input  logic [DIM_W-1:0]       cfg_width,
   input  logic [DIM_W-1:0]       cfg_height,
   input  logic [DIM_W-1:0]       cfg_chans,
   conv_window_addr_gen_if.master out_bus,
   output logic                   busy,
   output logic                   done,
   output logic                   cfg_err
);

   localparam int PROD_W = 3 * DIM_W;
   localparam int CMP_W  = (PROD_W > ADDR_W) ? PROD_W : ADDR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;

   state_t state, state_nxt;

   logic [DIM_W-1:0]   w_q, h_q, c_q;
   logic [ADDR_W-1:0]  plane_q;
   logic [ADDR_W-1:0]  win_base_q, chan_off_q, row_off_q;
   logic [DIM_W-1:0]   oy_q, ox_q, ch_q;
   logic [1:0]         ky_q, kx_q;
   logic [3:0]         kidx_q;

   logic [2*DIM_W-1:0] wh;
   logic [CMP_W-1:0]   total;
   logic               setup_err;
   logic               fire;
   logic               last_kx, last_ky, last_ch, last_ox, last_oy;
   logic               win_last, frame_last;

   // Multipliers are only used for the one-cycle setup checks, never in RUN.
   assign wh        = (2*DIM_W)'(w_q) * (2*DIM_W)'(h_q);
   assign total     = CMP_W'(wh) * CMP_W'(c_q);
   assign setup_err = (w_q < DIM_W'(3)) || (h_q < DIM_W'(3)) || (c_q == '0) ||
                      (total > (CMP_W'(1) << ADDR_W));

   assign fire       = (state == S_RUN) && out_bus.out_ready;
   assign last_kx    = (kx_q == 2'd2);
   assign last_ky    = (ky_q == 2'd2);
   assign last_ch    = (ch_q == c_q - DIM_W'(1));
   assign last_ox    = (ox_q == w_q - DIM_W'(3));
   assign last_oy    = (oy_q == h_q - DIM_W'(3));
   assign win_last   = last_kx && last_ky && last_ch;
   assign frame_last = win_last && last_ox && last_oy;

   // Outputs are decoded from registers only, so they hold during a stall.
   assign out_bus.out_valid      = (state == S_RUN);
   assign out_bus.out_addr       = win_base_q + chan_off_q + row_off_q + ADDR_W'(kx_q);
   assign out_bus.out_kidx       = kidx_q;
   assign out_bus.out_chan       = ch_q;
   assign out_bus.out_win_last   = (state == S_RUN) && win_last;
   assign out_bus.out_frame_last = (state == S_RUN) && frame_last;
   assign busy                   = (state == S_SETUP) || (state == S_RUN);
   assign done                   = (state == S_DONE);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (start) state_nxt = S_SETUP;
         S_SETUP: state_nxt = setup_err ? S_DONE : S_RUN;
         S_RUN:   if (fire && frame_last) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         w_q        <= '0;
         h_q        <= '0;
         c_q        <= '0;
         plane_q    <= '0;
         cfg_err    <= 1'b0;
         win_base_q <= '0;
         chan_off_q <= '0;
         row_off_q  <= '0;
         oy_q       <= '0;
         ox_q       <= '0;
         ch_q       <= '0;
         ky_q       <= '0;
         kx_q       <= '0;
         kidx_q     <= '0;
      end else begin
         if (state == S_IDLE && start) begin
            w_q     <= cfg_width;
            h_q     <= cfg_height;
            c_q     <= cfg_chans;
            cfg_err <= 1'b0;
         end

         if (state == S_SETUP) begin
            plane_q    <= ADDR_W'(wh);
            cfg_err    <= setup_err;
            win_base_q <= '0;
            chan_off_q <= '0;
            row_off_q  <= '0;
            oy_q       <= '0;
            ox_q       <= '0;
            ch_q       <= '0;
            ky_q       <= '0;
            kx_q       <= '0;
            kidx_q     <= '0;
         end

         // Innermost kx, then ky, c, ox, oy; every offset advances by addition.
         if (fire) begin
            if (!last_kx) begin
               kx_q   <= kx_q + 2'd1;
               kidx_q <= kidx_q + 4'd1;
            end else begin
               kx_q <= '0;
               if (!last_ky) begin
                  ky_q      <= ky_q + 2'd1;
                  kidx_q    <= kidx_q + 4'd1;
                  row_off_q <= row_off_q + ADDR_W'(w_q);
               end else begin
                  ky_q      <= '0;
                  kidx_q    <= '0;
                  row_off_q <= '0;
                  if (!last_ch) begin
                     ch_q       <= ch_q + DIM_W'(1);
                     chan_off_q <= chan_off_q + plane_q;
                  end else begin
                     ch_q       <= '0;
                     chan_off_q <= '0;
                     if (!last_ox) begin
                        ox_q       <= ox_q + DIM_W'(1);
                        win_base_q <= win_base_q + ADDR_W'(1);
                     end else begin
                        ox_q <= '0;
                        // Base sits at oy*W + W-3, so +3 lands on the next row start.
                        if (!last_oy) begin
                           oy_q       <= oy_q + DIM_W'(1);
                           win_base_q <= win_base_q + ADDR_W'(3);
                        end else begin
                           oy_q       <= '0;
                           win_base_q <= '0;
                        end
                     end
                  end
               end
            end
         end
      end
   end

endmodule
